// File: rtl/seg_display_arbiter.sv
// Three-client arbiter for a shared 4-digit multiplexed 7-segment display.
// Round-robin ownership with minimum hold, forced blank gap and continuous scan.
module seg_display_arbiter #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned MIN_HOLD     = 25000000,
  parameter int unsigned BLANK_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [31:0] seg_data0,
  input  logic [31:0] seg_data1,
  input  logic [31:0] seg_data2,
  output logic [2:0]  grant,
  output logic        busy,
  output logic [3:0]  digit_sel,
  output logic [7:0]  segments
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam int unsigned BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX     = HW'(MIN_HOLD);
  localparam logic [BW-1:0] BLANK_LAST   = BW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OWNED, BLANK} state_t;

  state_t          state, state_next;
  logic [2:0]      grant_next;
  logic [2:0]      winner;
  logic [1:0]      last_owner;
  logic [HW-1:0]   hold_cnt;
  logic [BW-1:0]   blank_cnt;
  logic [RW-1:0]   refresh_cnt;
  logic [1:0]      digit_idx;
  logic [31:0]     frame;
  logic            blank_done, hold_done, owner_req, others_req;

  assign blank_done = (blank_cnt == BLANK_LAST);
  assign hold_done  = (hold_cnt == HOLD_MAX);
  assign owner_req  = |(req & grant);
  assign others_req = |(req & ~grant);
  assign busy       = |grant;

  // Search begins at the client after last_owner, so the previous owner
  // only wins when nobody else is asking.
  always_comb begin
    winner = '0;
    case (last_owner)
      2'd0: winner = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
      2'd1: winner = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
      default: winner = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = OWNED;
      OWNED:   if (!owner_req || (hold_done && others_req)) state_next = BLANK;
      BLANK:   if (blank_done) state_next = (|req) ? OWNED : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_next = '0;
    case (state)
      IDLE:    grant_next = winner;
      OWNED:   grant_next = (state_next == OWNED) ? grant : '0;
      BLANK:   grant_next = blank_done ? winner : '0;
      default: grant_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= '0;
      last_owner <= 2'd2;
      hold_cnt   <= '0;
      blank_cnt  <= '0;
    end else begin
      grant <= grant_next;
      if (state != OWNED && grant_next != '0) begin
        last_owner <= {winner[2], winner[1]};
        hold_cnt   <= '0;
      end else if (state == OWNED && !hold_done) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (state != BLANK)   blank_cnt <= '0;
      else if (!blank_done) blank_cnt <= blank_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_comb begin
    frame = '1;
    case (grant)
      3'b001:  frame = seg_data0;
      3'b010:  frame = seg_data1;
      3'b100:  frame = seg_data2;
      default: frame = '1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_sel <= '1;
      segments  <= '1;
    end else if (grant == '0) begin
      digit_sel <= '1;
      segments  <= '1;
    end else begin
      case (digit_idx)
        2'd0:    begin digit_sel <= 4'b1110; segments <= frame[7:0];   end
        2'd1:    begin digit_sel <= 4'b1101; segments <= frame[15:8];  end
        2'd2:    begin digit_sel <= 4'b1011; segments <= frame[23:16]; end
        default: begin digit_sel <= 4'b0111; segments <= frame[31:24]; end
      endcase
    end
  end

endmodule

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: clk cycles per digit scan slot.
REQ-002 SHALL have parameter MIN_HOLD, default 25000000: minimum clk cycles an owner keeps the display while another client requests.
REQ-003 SHALL have parameter BLANK_CYCLES, default 50000: clk cycles of forced blank between owners.
REQ-004 SHALL have port clk, input, 1: system clock (50 MHz); all logic on posedge.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port req, input, 3: per-client display request; bit i is client i.
REQ-007 SHALL have ports seg_data0, seg_data1, seg_data2, input, 32 each: client frame, active-low segments; byte k ([8k+7:8k]) drives digit k, where digit 0 is rightmost.
REQ-008 SHALL have port grant, output, 3: one-hot registered grant; 0 when no owner.
REQ-009 SHALL have port busy, output, 1: high iff grant != 0.
REQ-010 SHALL have port digit_sel, output, 4: active-low digit enable.
REQ-011 SHALL have port segments, output, 8: active-low segment drive.

Function
REQ-012 SHALL implement states IDLE, OWNED and BLANK.
REQ-013 SHALL use round-robin arbitration: search starts at the client after last_owner (last_owner resets to 2, so client 0 is searched first).
REQ-014 IDLE: when any req bit is high, SHALL set grant one-hot to the arbitration winner on the next edge, load last_owner, clear hold_cnt and enter OWNED.
REQ-015 OWNED: hold_cnt SHALL increment each cycle, saturating at MIN_HOLD.
REQ-016 OWNED, owner's req low: SHALL clear grant and enter BLANK on the next edge, regardless of hold_cnt.
REQ-017 OWNED, hold_cnt == MIN_HOLD and any other req bit high: SHALL clear grant and enter BLANK on the next edge.
REQ-018 OWNED, hold_cnt == MIN_HOLD and no other request: owner SHALL keep grant indefinitely.
REQ-019 BLANK: SHALL count BLANK_CYCLES cycles; grant SHALL stay 0 throughout.
REQ-020 At BLANK end with any req high: SHALL grant the round-robin winner and enter OWNED. The previous owner wins only if it is the sole requester.
REQ-021 At BLANK end with no req high: SHALL enter IDLE.
REQ-022 Request changes during BLANK SHALL be ignored until the last BLANK cycle; the arbitration sample is taken on that cycle.
REQ-023 Scan: refresh_cnt SHALL count 0..REFRESH_DIV-1 and wrap. On wrap, digit_idx SHALL increment mod 4 (3 -> 0). Scan SHALL run continuously in every state.
REQ-024 digit_sel SHALL be registered from digit_idx: 0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111. digit_sel SHALL be 1111 when grant == 0.
REQ-025 segments SHALL be registered as byte digit_idx of the owner's seg_data, with 1-cycle latency from digit_idx and grant. segments SHALL be 8'hFF when grant == 0.
REQ-026 Owner seg_data changes SHALL appear on segments one cycle after the change, for the currently scanned digit.
REQ-027 grant SHALL never have more than one bit set; busy SHALL be derived from the registered grant.
REQ-028 Counter widths SHALL hold their parameter values without overflow; hold_cnt SHALL saturate and never wrap.

Reset
REQ-029 Reset assertion SHALL immediately set: state IDLE, grant 000, busy 0, digit_sel 1111, segments 8'hFF, digit_idx 0, refresh_cnt 0, hold_cnt 0, blank counter 0, last_owner 2.
REQ-030 Reset asserted mid-OWNED or mid-BLANK SHALL abort the operation. The first grant after release SHALL follow REQ-014.

Verification (bench parameters: REFRESH_DIV=4, MIN_HOLD=8, BLANK_CYCLES=4)
REQ-031 Reset scenario: assert reset at any cycle -> outputs immediately match REQ-029; after release with req=000, outputs stay at those values.
REQ-032 Single owner: req=010, seg_data1=0x11223344 -> grant=010 one edge later. With the registered outputs at digit_idx 0 showing digit_sel=1110/segments=0x44, the next slot shows 1101/0x33, then 1011/0x22, then 0111/0x11, then back to 1110/0x44.
REQ-033 Rotation: req=101 from IDLE -> grant=001 for 9 cycles -> 000 for 4 cycles -> 100 for 9 cycles -> 000 for 4 cycles -> 001.
REQ-034 Early release: owner 0 drops req at hold_cnt=3 while req2 is low -> grant=000 next edge. After 4 blank cycles with req=000, state is IDLE and digit_sel=1111.
REQ-035 Late request: owner 1 held 20 cycles, then req0 rises -> grant=000 next edge, grant=001 after 4 blank cycles.
REQ-036 Reset mid-BLANK with req=111 -> grant=000 during reset; grant=001 one edge after release.
